// File: rtl/cnt_vote_chk_pkg.sv
// Shared types and constants for the three-lane counter vote checker.
// The optional idle watchdog is enabled by defining CNT_VOTE_CHK_TIMEOUT_EN.
package cnt_vote_chk_pkg;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam int LANE_A = 0;
  localparam int LANE_B = 1;
  localparam int LANE_C = 2;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_ERR_W  = 8;
  localparam int DEF_SYNC_N = 2;

  // Saturating increment used by the error counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    logic [31:0] res;
    if (val >= max_val) begin
      res = max_val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cnt_vote_chk_maj3_vote.sv
// Bitwise two-of-three majority over the lanes plus the per-lane disagreement mask.
module maj3_vote
  import cnt_vote_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] vote,
  output logic [2:0]       lane_bad
);

  // Majority and per-lane disagreement against the majority.
  always_comb begin
    vote             = (a & b) | (a & c) | (b & c);
    lane_bad         = 3'b000;
    lane_bad[LANE_A] = (a != vote);
    lane_bad[LANE_B] = (b != vote);
    lane_bad[LANE_C] = (c != vote);
  end

endmodule

// File: rtl/cnt_vote_chk.sv
// Votes three counter lanes, checks the increment sequence and tracks lock/fault.
// Define CNT_VOTE_CHK_TIMEOUT_EN to add the idle watchdog driving timeout.
module cnt_vote_chk
  import cnt_vote_chk_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int SYNC_N = DEF_SYNC_N
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [WIDTH-1:0] inc,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] vote,
  output logic             vote_vld,
  output logic             mismatch,
  output logic [2:0]       lane_bad,
  output logic             seq_err,
  output logic             locked,
  output logic             fault,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       first_bad,
  output logic             timeout
);

  localparam int             GW     = $clog2(SYNC_N + 1);
  localparam logic [GW-1:0]  SYNC_V = GW'(SYNC_N);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [WIDTH-1:0] r_a_q, r_a_d, r_b_q, r_b_d, r_c_q, r_c_d;
  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] vote_q, vote_d, prev_q, prev_d;
  logic             vote_vld_q, vote_vld_d, mismatch_q, mismatch_d, seq_err_q, seq_err_d;
  logic [2:0]       lane_bad_q, lane_bad_d, first_bad_q, first_bad_d;
  state_e           state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic [ERR_W-1:0] err_q, err_d, err_inc_s;
  logic [WIDTH-1:0] maj_s, exp_s;
  logic [2:0]       lb_s;
  logic             mm_s, seq_bad_s, bad_s;

  maj3_vote #(.WIDTH(WIDTH)) u_vote (
    .a        (r_a_q),
    .b        (r_b_q),
    .c        (r_c_q),
    .vote     (maj_s),
    .lane_bad (lb_s)
  );

  assign mm_s      = |lb_s;
  assign exp_s     = prev_q + WIDTH'(1);
  assign seq_bad_s = (maj_s != exp_s);
  assign bad_s     = mm_s | seq_bad_s;
  assign err_inc_s = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);

`ifdef CNT_VOTE_CHK_TIMEOUT_EN
  localparam logic [WIDTH:0] IDLE_MAX = {1'b1, {WIDTH{1'b0}}};
  logic [WIDTH:0] idle_q, idle_d;
  logic           timeout_q, timeout_d;
`endif

  // Capture, vote, sequence check and lock/fault state machine.
  always_comb begin
    r_a_d       = r_a_q;
    r_b_d       = r_b_q;
    r_c_d       = r_c_q;
    s1_vld_d    = en;
    vote_d      = vote_q;
    vote_vld_d  = 1'b0;
    mismatch_d  = mismatch_q;
    lane_bad_d  = lane_bad_q;
    prev_d      = prev_q;
    seq_err_d   = seq_err_q;
    state_d     = state_q;
    good_d      = good_q;
    err_d       = err_q;
    first_bad_d = first_bad_q;
`ifdef CNT_VOTE_CHK_TIMEOUT_EN
    idle_d      = idle_q;
    timeout_d   = timeout_q;
`endif

    if (en) begin
      r_a_d = ina;
      r_b_d = inb;
      r_c_d = inc;
    end else begin
      r_a_d = r_a_q;
    end

    if (s1_vld_q) begin
      vote_d     = maj_s;
      vote_vld_d = 1'b1;
      mismatch_d = mm_s;
      lane_bad_d = lb_s;
      prev_d     = maj_s;
    end else begin
      vote_vld_d = 1'b0;
    end

`ifdef CNT_VOTE_CHK_TIMEOUT_EN
    if (en || (state_q != LOCK)) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + (WIDTH+1)'(1);
    end
`endif

    // clr suppresses any FSM/counter effect of a coincident sample.
    if (clr) begin
      state_d     = ACQ;
      good_d      = '0;
      err_d       = '0;
      first_bad_d = 3'b000;
      seq_err_d   = 1'b0;
`ifdef CNT_VOTE_CHK_TIMEOUT_EN
      idle_d      = '0;
      timeout_d   = 1'b0;
`endif
    end else if (s1_vld_q) begin
      case (state_q)
        ACQ: begin
          seq_err_d = 1'b0;
          if (mm_s) begin
            good_d = '0;
          end else if (!seq_bad_s) begin
            good_d = good_q + GW'(1);
          end else begin
            good_d = GW'(1);
          end
          if (good_d == SYNC_V) begin
            state_d = LOCK;
          end else begin
            state_d = ACQ;
          end
        end
        LOCK: begin
          seq_err_d = seq_bad_s;
          if (bad_s) begin
            state_d = FAULT;
            err_d   = err_inc_s;
            if (first_bad_q == 3'b000) begin
              first_bad_d = lb_s;
            end else begin
              first_bad_d = first_bad_q;
            end
          end else begin
            state_d = LOCK;
          end
        end
        FAULT: begin
          seq_err_d = seq_bad_s;
          if (bad_s) begin
            err_d = err_inc_s;
          end else begin
            err_d = err_q;
          end
        end
        default: begin
          state_d = ACQ;
        end
      endcase
`ifdef CNT_VOTE_CHK_TIMEOUT_EN
    end else if ((state_q == LOCK) && (idle_d == IDLE_MAX)) begin
      state_d   = FAULT;
      timeout_d = 1'b1;
      err_d     = err_inc_s;
`endif
    end else begin
      state_d = state_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_a_q       <= '0;
      r_b_q       <= '0;
      r_c_q       <= '0;
      s1_vld_q    <= 1'b0;
      vote_q      <= '0;
      vote_vld_q  <= 1'b0;
      mismatch_q  <= 1'b0;
      lane_bad_q  <= 3'b000;
      prev_q      <= '0;
      seq_err_q   <= 1'b0;
      state_q     <= ACQ;
      good_q      <= '0;
      err_q       <= '0;
      first_bad_q <= 3'b000;
`ifdef CNT_VOTE_CHK_TIMEOUT_EN
      idle_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      r_a_q       <= r_a_d;
      r_b_q       <= r_b_d;
      r_c_q       <= r_c_d;
      s1_vld_q    <= s1_vld_d;
      vote_q      <= vote_d;
      vote_vld_q  <= vote_vld_d;
      mismatch_q  <= mismatch_d;
      lane_bad_q  <= lane_bad_d;
      prev_q      <= prev_d;
      seq_err_q   <= seq_err_d;
      state_q     <= state_d;
      good_q      <= good_d;
      err_q       <= err_d;
      first_bad_q <= first_bad_d;
`ifdef CNT_VOTE_CHK_TIMEOUT_EN
      idle_q      <= idle_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign vote      = vote_q;
  assign vote_vld  = vote_vld_q;
  assign mismatch  = mismatch_q;
  assign lane_bad  = lane_bad_q;
  assign seq_err   = seq_err_q;
  assign locked    = (state_q == LOCK);
  assign fault     = (state_q == FAULT);
  assign err_cnt   = err_q;
  assign first_bad = first_bad_q;
`ifdef CNT_VOTE_CHK_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_vote_chk.sv
// Directed bench for cnt_vote_chk with a per-cycle reference model and literal spot checks.
// Build with CNT_VOTE_CHK_TIMEOUT_EN to also exercise the idle watchdog.
module tb_cnt_vote_chk;
  localparam int W  = 5;
  localparam int EW = 2;
  localparam int SN = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         en    = 1'b0;
  logic         clr   = 1'b0;
  logic [W-1:0] ina   = '0;
  logic [W-1:0] inb   = '0;
  logic [W-1:0] inc   = '0;
  logic [W-1:0] vote;
  logic         vote_vld, mismatch, seq_err, locked, fault, timeout;
  logic [2:0]   lane_bad, first_bad;
  logic [EW-1:0] err_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  cnt_vote_chk #(.WIDTH(W), .ERR_W(EW), .SYNC_N(SN)) dut (
    .clock(clock), .reset(reset), .ina(ina), .inb(inb), .inc(inc), .en(en), .clr(clr),
    .vote(vote), .vote_vld(vote_vld), .mismatch(mismatch), .lane_bad(lane_bad),
    .seq_err(seq_err), .locked(locked), .fault(fault), .err_cnt(err_cnt),
    .first_bad(first_bad), .timeout(timeout)
  );

  // Model state: mode 0=acquiring, 1=locked, 2=faulted.
  int m_mode, m_good, m_prev, m_err, m_first, m_idle;
  int p_vld, p_a, p_b, p_c;
  int e_vote, e_vld, e_mm, e_lb, e_seq, e_to;
  int m_live = 0;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int maj(input int a, input int b, input int c);
    int r = 0;
    for (int i = 0; i < W; i++) begin
      if ((((a >> i) & 1) + ((b >> i) & 1) + ((c >> i) & 1)) >= 2) r += (1 << i);
    end
    return r;
  endfunction

  function automatic int sat(input int x);
    return (x < (1 << EW) - 1) ? x + 1 : x;
  endfunction

  task automatic model_step();
    int v, lb, expv, old_mode;
    m_live = 1;
    if (!reset) begin
      m_mode = 0; m_good = 0; m_prev = 0; m_err = 0; m_first = 0; m_idle = 0;
      p_vld = 0; p_a = 0; p_b = 0; p_c = 0;
      e_vote = 0; e_vld = 0; e_mm = 0; e_lb = 0; e_seq = 0; e_to = 0;
      return;
    end
    old_mode = m_mode;
    if (p_vld != 0) begin
      v = maj(p_a, p_b, p_c);
      lb = 0;
      if (p_a != v) lb += 1;
      if (p_b != v) lb += 2;
      if (p_c != v) lb += 4;
      expv = (m_prev + 1) % (1 << W);
      e_vote = v; e_vld = 1; e_mm = (lb != 0); e_lb = lb;
      if (!clr) begin
        if (m_mode == 0) begin
          e_seq = 0;
          if (lb != 0) m_good = 0;
          else if (v == expv) m_good++;
          else m_good = 1;
          if (m_good >= SN) m_mode = 1;
        end else begin
          e_seq = (v != expv);
          if (lb != 0 || v != expv) begin
            if (m_mode == 1 && m_first == 0) m_first = lb;
            m_mode = 2;
            m_err = sat(m_err);
          end
        end
      end
      m_prev = v;
    end else begin
      e_vld = 0;
    end
`ifdef CNT_VOTE_CHK_TIMEOUT_EN
    if (!clr) begin
      if (en || old_mode != 1) m_idle = 0;
      else m_idle++;
      if (old_mode == 1 && m_idle == (1 << W)) begin
        m_mode = 2; e_to = 1; m_err = sat(m_err);
      end
    end
`endif
    if (clr) begin
      m_mode = 0; m_good = 0; m_err = 0; m_first = 0; e_seq = 0; e_to = 0; m_idle = 0;
    end
    p_vld = en; p_a = ina; p_b = inb; p_c = inc;
  endtask

  // Model advance on each rising edge, then compare once outputs have settled.
  initial begin
    forever begin
      @(posedge clock);
      model_step();
      #1;
      if (m_live != 0) begin
        chk("vote",      int'(vote),      e_vote);
        chk("vote_vld",  int'(vote_vld),  e_vld);
        chk("mismatch",  int'(mismatch),  e_mm);
        chk("lane_bad",  int'(lane_bad),  e_lb);
        chk("seq_err",   int'(seq_err),   e_seq);
        chk("locked",    int'(locked),    int'(m_mode == 1));
        chk("fault",     int'(fault),     int'(m_mode == 2));
        chk("err_cnt",   int'(err_cnt),   m_err);
        chk("first_bad", int'(first_bad), m_first);
        chk("timeout",   int'(timeout),   e_to);
      end
    end
  end

  task automatic step(input int a, input int b, input int c, input logic e, input logic cl);
    ina = W'(a); inb = W'(b); inc = W'(c); en = e; clr = cl;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    step(0, 0, 0, 1'b0, 1'b0);
    step(0, 0, 0, 1'b0, 1'b0);
    chk("lit_reset_vote", int'(vote), 0);
    chk("lit_reset_locked", int'(locked), 0);
    chk("lit_reset_err", int'(err_cnt), 0);
    reset = 1'b1;

    // Three matching lanes counting up; lock after the second valid sample.
    for (int v = 0; v < 8; v++) begin
      step(v, v, v, 1'b1, 1'b0);
      if (v == 2) begin
        chk("lit_lock_after_2", int'(locked), 1);
        chk("lit_vote_1", int'(vote), 1);
      end
    end
    // Jump 7 -> 9 on all lanes: sequence error without lane disagreement.
    step(9, 9, 9, 1'b1, 1'b0);
    step(0, 0, 0, 1'b0, 1'b0);
    chk("lit_jump_seq_err", int'(seq_err), 1);
    chk("lit_jump_mismatch", int'(mismatch), 0);
    chk("lit_jump_fault", int'(fault), 1);
    chk("lit_jump_first_bad", int'(first_bad), 0);
    chk("lit_jump_err", int'(err_cnt), 1);

    step(0, 0, 0, 1'b0, 1'b1);
    chk("lit_clr_err", int'(err_cnt), 0);
    chk("lit_clr_fault", int'(fault), 0);

    // Relock and run across the 31 -> 0 wrap.
    for (int k = 10; k < 36; k++) step(k % 32, k % 32, k % 32, 1'b1, 1'b0);
    step(0, 0, 0, 1'b0, 1'b0);
    chk("lit_wrap_locked", int'(locked), 1);
    chk("lit_wrap_seq_err", int'(seq_err), 0);
    chk("lit_wrap_vote", int'(vote), 3);

    // Lane C stuck at zero; error count saturates at 3 with ERR_W=2.
    for (int v = 4; v < 10; v++) begin
      step(v, v, 0, 1'b1, 1'b0);
      if (v == 5) begin
        chk("lit_stuck_vote", int'(vote), 4);
        chk("lit_stuck_lane_bad", int'(lane_bad), 4);
        chk("lit_stuck_first_bad", int'(first_bad), 4);
        chk("lit_stuck_err1", int'(err_cnt), 1);
      end
    end
    step(0, 0, 0, 1'b0, 1'b0);
    chk("lit_sat_err", int'(err_cnt), 3);
    chk("lit_sat_fault", int'(fault), 1);
    step(0, 0, 0, 1'b0, 1'b0);
    step(0, 0, 0, 1'b0, 1'b0);
    chk("lit_idle_vld", int'(vote_vld), 0);

    // clr coincides with a bad sample: sample updates vote but not counters.
    step(10, 10, 0, 1'b1, 1'b0);
    step(11, 11, 11, 1'b1, 1'b1);
    chk("lit_clrwin_err", int'(err_cnt), 0);
    chk("lit_clrwin_fault", int'(fault), 0);
    chk("lit_clrwin_vote", int'(vote), 10);
    step(12, 12, 12, 1'b1, 1'b0);
    chk("lit_relock_not_yet", int'(locked), 0);
    step(13, 13, 13, 1'b1, 1'b0);
    chk("lit_relock", int'(locked), 1);

    // Mid-run reset discards the in-flight sample.
    reset = 1'b0;
    step(14, 14, 14, 1'b1, 1'b0);
    chk("lit_mid_reset_vote", int'(vote), 0);
    chk("lit_mid_reset_locked", int'(locked), 0);
    reset = 1'b1;
    step(0, 0, 0, 1'b0, 1'b0);
    chk("lit_discard_vld", int'(vote_vld), 0);

`ifdef CNT_VOTE_CHK_TIMEOUT_EN
    for (int v = 0; v < 3; v++) step(v, v, v, 1'b1, 1'b0);
    for (int i = 0; i < 34; i++) step(0, 0, 0, 1'b0, 1'b0);
    chk("lit_timeout", int'(timeout), 1);
    chk("lit_timeout_fault", int'(fault), 1);
    chk("lit_timeout_err", int'(err_cnt), 1);
    step(0, 0, 0, 1'b0, 1'b1);
    chk("lit_timeout_clr", int'(timeout), 0);
`endif

    step(0, 0, 0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
